dbus_ctrl: RTL and testbench
============================

# dbus_ctrl

Data-bus controller between the mem stage's memory-request outputs and an external Wishbone-style data bus. Registers each mem-stage access onto the bus, holds the pipeline with a stall request until the slave acknowledges, and returns the read data on mem_data_i. Keeps a completed read result while the pipeline is frozen by another stage, so the access is never reissued.

## Interface

- TIMEOUT_CYCLES, 16: number of BUSY cycles without ack before the access is aborted (only with DBUS_TIMEOUT_EN); legal range 1..255.

Reset is asynchronous and active-low (`rst` low = reset). All state is on the rising edge of `clk`.

- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- cpu_ce_i  in  1  access request from mem stage (mem_ce_o)
- cpu_we_i  in  1  1 = store, 0 = load (mem_we_o)
- cpu_addr_i  in  32  byte address (mem_addr_o)
- cpu_sel_i  in  4  byte lanes, bit3 = bits 31:24 (mem_sel_o)
- cpu_data_i  in  32  store data (mem_data_o)
- cpu_data_o  out  32  load data to mem stage (mem_data_i)
- stall_i  in  1  mem stage held by pipeline control this cycle
- flush_i  in  1  pipeline flush
- stallreq_o  out  1  request to pipeline control to hold the pipeline
- err_o  out  1  one-cycle timeout pulse; constant 0 without DBUS_TIMEOUT_EN
- wb_cyc_o, wb_stb_o  out  1 each  bus cycle / strobe
- wb_we_o  out  1  bus write enable
- wb_adr_o  out  32  bus address
- wb_sel_o  out  4  bus byte selects
- wb_dat_o  out  32  bus write data
- wb_dat_i  in  32  bus read data
- wb_ack_i  in  1  slave acknowledge

## Operation

- States: IDLE, BUSY, HOLD. Reset state is IDLE.
- IDLE:
  - If cpu_ce_i=1 and flush_i=0: latch addr/sel/we/data onto wb_* outputs, set cyc=stb=1, go to BUSY.
  - stallreq_o = cpu_ce_i & ~flush_i (combinational).
  - cpu_data_o = 0.
- BUSY:
  - If flush_i=1: drop cyc/stb/we, clear the counter, go to IDLE. Flush has priority over ack.
  - Else if wb_ack_i=1: drop cyc/stb/we. For a load, capture wb_dat_i into rd_buf (a store leaves rd_buf unchanged). Go to HOLD if stall_i=1, else to IDLE.
  - Else: hold all wb_* outputs stable; counter increments.
  - stallreq_o = ~wb_ack_i. On the ack cycle cpu_data_o = wb_dat_i; otherwise cpu_data_o = 0.
- HOLD:
  - stallreq_o = 0; cpu_data_o = rd_buf.
  - When stall_i=0, or flush_i=1, go to IDLE.
  - The pending cpu_ce_i is ignored, so no reissue occurs.
- wb_adr_o, wb_sel_o, wb_dat_o keep their last value when idle. Only cyc/stb/we are cleared.
- Loads return all 32 bits. Lane extraction is done by the mem stage.

## Timing

- Reset values: state IDLE; wb_cyc_o, wb_stb_o, wb_we_o, err_o = 0; wb_adr_o, wb_sel_o, wb_dat_o, rd_buf = 0; counter 0; cpu_data_o = 0; stallreq_o = cpu_ce_i (IDLE rule).
- A request seen in cycle N drives the bus from cycle N+1.
- With ack in cycle N+k, stallreq_o is low in N+k, and the mem stage captures cpu_data_o at the edge ending N+k.
- Minimum access is 2 cycles (ack in N+1).
- Back-to-back accesses: a new request is accepted in the IDLE cycle following the ack.
- Reset asserted mid-access clears state immediately (cyc/stb drop asynchronously). No completion is reported.
- wb_ack_i outside BUSY is ignored.

## Configuration

- DBUS_TIMEOUT_EN defined:
  - An 8-bit counter runs in BUSY.
  - When it reaches TIMEOUT_CYCLES-1 with no ack, the block behaves as an ack with data 0: cyc/stb drop, rd_buf is loaded with 0, err_o pulses high for that one cycle, and stallreq_o goes low that cycle.
  - Next state is HOLD or IDLE per stall_i.
- DBUS_TIMEOUT_EN undefined: no counter; BUSY waits indefinitely; err_o tied 0.

## Test plan

- Load word: addr 0x100, sel 1111, ack after 3 BUSY cycles with 0xDEADBEEF -> stallreq_o high 3 cycles then low; cpu_data_o = 0xDEADBEEF on the ack cycle; cyc low the next cycle.
- Byte store: addr 0x203, sel 0001, data 0x5A5A5A5A, ack in first BUSY cycle -> wb_we_o=1, wb_sel_o=0001, wb_adr_o=0x203 for one cycle; stallreq_o low on the ack cycle.
- Hold: load acked with 0x12345678 while stall_i=1 for 4 cycles -> HOLD; cpu_data_o stays 0x12345678; no second cyc; IDLE once stall_i=0.
- Flush: flush_i=1 in the second BUSY cycle, ack arrives the same cycle -> cyc/stb drop, IDLE, rd_buf unchanged, no HOLD.
- Timeout (DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4): no ack -> cyc drops after the 4th BUSY cycle; err_o single-cycle pulse; cpu_data_o = 0; stallreq_o low.
- Async reset: rst low mid-BUSY -> cyc/stb/we = 0 without a clock edge; after release, state is IDLE.

Source files
------------

// File: rtl/dbus_ctrl_if.sv
// dbus_ctrl_if -- Wishbone-style data-bus signal bundle.
//   cyc/stb/we   : bus cycle, strobe, write enable (master -> slave)
//   adr/sel      : byte address, byte-lane selects, sel[3] = bits 31:24
//   dat_w        : write data (master -> slave)
//   dat_r, ack   : read data and acknowledge (slave -> master)
interface dbus_ctrl_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack);
endinterface

// File: rtl/dbus_ctrl.sv
// dbus_ctrl -- data-bus controller between the mem stage and a Wishbone-style bus.
// Registers each mem-stage access onto the bus, stalls the pipeline until ack,
// returns load data, and parks a completed load in rd_buf while the pipeline
// is frozen elsewhere so the access is never reissued.
//
// Ports:
//   clk, rst      : clock, asynchronous active-low reset
//   cpu_ce_i/we_i/addr_i/sel_i/data_i : access request from the mem stage
//   cpu_data_o    : load data to the mem stage
//   stall_i       : mem stage held by pipeline control
//   flush_i       : pipeline flush
//   stallreq_o    : hold-the-pipeline request
//   err_o         : one-cycle bus timeout pulse
//   wb            : bus master side (dbus_ctrl_if.master)
//
// Build option: define DBUS_TIMEOUT_EN to abort accesses after TIMEOUT_CYCLES
// BUSY cycles without ack (completes as a load of 0 and pulses err_o).
module dbus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic        stallreq_o,
  output logic        err_o,
  dbus_ctrl_if.master wb
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("dbus_ctrl: TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } req_t;

  state_t      state, state_nx;
  req_t        req_q;
  logic        cyc_q;
  logic [31:0] rd_buf;
  logic        accept, ack_ok, tmo;

  assign accept = (state == IDLE) & cpu_ce_i & ~flush_i;
  // flush wins over ack: a flushed access completes nothing
  assign ack_ok = (state == BUSY) & ~flush_i & wb.ack;

`ifdef DBUS_TIMEOUT_EN
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] cnt;

  assign tmo = (state == BUSY) & ~flush_i & ~wb.ack & (cnt == CNT_LAST);

  // counts un-acked BUSY cycles; zero whenever the access ends or is idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                            cnt <= '0;
    else if ((state == BUSY) & ~flush_i & ~wb.ack & ~tmo) cnt <= cnt + 8'd1;
    else                                                  cnt <= '0;
  end
`else
  assign tmo = 1'b0;
`endif

  assign err_o = tmo;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    stallreq_o = 1'b0;
    cpu_data_o = 32'h0;
    case (state)
      IDLE: begin
        stallreq_o = cpu_ce_i & ~flush_i;
        if (accept) state_nx = BUSY;
      end
      BUSY: begin
        stallreq_o = ~wb.ack & ~tmo;
        if (wb.ack) cpu_data_o = wb.dat_r;
        if (flush_i)            state_nx = IDLE;
        else if (wb.ack | tmo)  state_nx = stall_i ? HOLD : IDLE;
      end
      HOLD: begin
        // pending cpu_ce_i is the already-completed access; do not reissue
        cpu_data_o = rd_buf;
        if (~stall_i | flush_i) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // bus registers: adr/sel/dat persist after the access, only cyc/stb/we drop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q  <= 1'b0;
      req_q  <= '0;
      rd_buf <= '0;
    end else if (accept) begin
      cyc_q  <= 1'b1;
      req_q  <= '{we: cpu_we_i, adr: cpu_addr_i, sel: cpu_sel_i, dat: cpu_data_i};
    end else if ((state == BUSY) & (flush_i | wb.ack | tmo)) begin
      cyc_q    <= 1'b0;
      req_q.we <= 1'b0;
      if (ack_ok & ~req_q.we) rd_buf <= wb.dat_r;
      else if (tmo)           rd_buf <= 32'h0;
    end
  end

  assign wb.cyc   = cyc_q;
  assign wb.stb   = cyc_q;
  assign wb.we    = req_q.we;
  assign wb.adr   = req_q.adr;
  assign wb.sel   = req_q.sel;
  assign wb.dat_w = req_q.dat;

endmodule

// File: tb/tb_dbus_ctrl.sv
// tb_dbus_ctrl -- directed bench for dbus_ctrl with a transaction-level model
// compared every cycle, plus hand-computed literal expectations.
module tb_dbus_ctrl;
  localparam int TO = 4;
`ifdef DBUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0, we = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [31:0] addr = '0, wdat = '0;
  logic [3:0]  sel = '0;
  logic [31:0] cpu_data;
  logic        stallreq, err;

  dbus_ctrl_if wb ();

  dbus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_ce_i(ce), .cpu_we_i(we), .cpu_addr_i(addr), .cpu_sel_i(sel),
    .cpu_data_i(wdat), .cpu_data_o(cpu_data),
    .stall_i(stall), .flush_i(flush),
    .stallreq_o(stallreq), .err_o(err),
    .wb(wb)
  );

  always #5 clk = ~clk;

  initial begin
    wb.ack   = 1'b0;
    wb.dat_r = '0;
  end

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---- model: one outstanding access, last bus fields, parked load result
  bit          m_busy, m_hold, m_we;
  logic [31:0] m_adr, m_dat, m_rd;
  logic [3:0]  m_sel;
  int          m_cnt;

  always @(negedge clk) begin
    bit          tmo, fin;
    logic [31:0] e_data;
    logic        e_stall;
    if (!rst) begin
      m_busy = 0; m_hold = 0; m_we = 0;
      m_adr = '0; m_dat = '0; m_rd = '0; m_sel = '0; m_cnt = 0;
    end
    tmo = TMO_EN && rst && m_busy && !wb.ack && !flush && (m_cnt == TO - 1);
    fin = m_busy && (wb.ack || tmo);
    if (m_busy) begin
      e_stall = !fin;
      e_data  = wb.ack ? wb.dat_r : 32'h0;
    end else if (m_hold) begin
      e_stall = 1'b0;
      e_data  = m_rd;
    end else begin
      e_stall = ce && !flush;
      e_data  = 32'h0;
    end
    chk("cyc",      wb.cyc,   m_busy);
    chk("stb",      wb.stb,   m_busy);
    chk("we",       wb.we,    m_busy && m_we);
    chk("adr",      wb.adr,   m_adr);
    chk("sel",      wb.sel,   m_sel);
    chk("dat_w",    wb.dat_w, m_dat);
    chk("stallreq", stallreq, e_stall);
    chk("cpu_data", cpu_data, e_data);
    chk("err",      err,      tmo);
    if (rst) begin
      if (m_busy) begin
        if (flush) begin
          m_busy = 0; m_cnt = 0;
        end else if (fin) begin
          m_busy = 0; m_cnt = 0; m_hold = stall;
          if (tmo)        m_rd = 32'h0;
          else if (!m_we) m_rd = wb.dat_r;
        end else m_cnt++;
      end else if (m_hold) begin
        if (!stall || flush) m_hold = 0;
      end else if (ce && !flush) begin
        m_busy = 1; m_cnt = 0;
        m_we = we; m_adr = addr; m_sel = sel; m_dat = wdat;
      end
    end
  end

  task automatic drive(input logic ce_v, we_v, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, input logic st, fl, ak, input logic [31:0] rd);
    @(posedge clk); #1;
    ce = ce_v; we = we_v; addr = a; sel = s; wdat = d;
    stall = st; flush = fl; wb.ack = ak; wb.dat_r = rd;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ce = 1'b1;
    @(negedge clk);
    chk("rst_cyc", wb.cyc, 0);
    chk("rst_stallreq", stallreq, 1);
    chk("rst_cpu_data", cpu_data, 0);
    chk("rst_adr", wb.adr, 0);
    @(posedge clk); #1;
    rst = 1'b1; ce = 1'b0;
    @(negedge clk);
    idle();

    // load word, ack after 3 BUSY cycles
    drive(1, 0, 32'h100, 4'hF, 0, 0, 0, 0, 0);
    chk("ld_req_stall", stallreq, 1);
    drive(1, 0, 32'h100, 4'hF, 0, 0, 0, 0, 0);
    chk("ld_cyc", wb.cyc, 1);
    chk("ld_adr", wb.adr, 32'h100);
    drive(1, 0, 32'h100, 4'hF, 0, 0, 0, 0, 0);
    chk("ld_stall2", stallreq, 1);
    drive(1, 0, 32'h100, 4'hF, 0, 0, 0, 1, 32'hDEADBEEF);
    chk("ld_data", cpu_data, 32'hDEADBEEF);
    chk("ld_ack_stall", stallreq, 0);
    idle();
    chk("ld_cyc_done", wb.cyc, 0);
    chk("ld_data_idle", cpu_data, 0);

    // byte store, ack in first BUSY cycle
    drive(1, 1, 32'h203, 4'h1, 32'h5A5A5A5A, 0, 0, 0, 0);
    drive(1, 1, 32'h203, 4'h1, 32'h5A5A5A5A, 0, 0, 1, 32'hFFFFFFFF);
    chk("st_we", wb.we, 1);
    chk("st_sel", wb.sel, 4'h1);
    chk("st_adr", wb.adr, 32'h203);
    chk("st_dat", wb.dat_w, 32'h5A5A5A5A);
    chk("st_stall", stallreq, 0);
    idle();
    chk("st_we_done", wb.we, 0);
    chk("st_adr_kept", wb.adr, 32'h203);

    // hold: ack while stalled, pending ce ignored, stray ack ignored
    drive(1, 0, 32'h300, 4'hF, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h300, 4'hF, 0, 1, 0, 1, 32'h12345678);
    chk("hd_ack_data", cpu_data, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h300, 4'hF, 0, 1, 0, (i == 1), 32'h0BAD0BAD);
      chk("hd_data", cpu_data, 32'h12345678);
      chk("hd_cyc", wb.cyc, 0);
      chk("hd_stall", stallreq, 0);
    end
    drive(1, 0, 32'h300, 4'hF, 0, 0, 0, 0, 0);
    chk("hd_release_data", cpu_data, 32'h12345678);
    idle();
    chk("hd_idle_data", cpu_data, 0);
    chk("hd_no_reissue", wb.cyc, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 32'h0BAD0BAD);
    chk("idle_ack_data", cpu_data, 0);

    // flush with simultaneous ack in second BUSY cycle
    drive(1, 0, 32'h400, 4'hF, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h400, 4'hF, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h400, 4'hF, 0, 1, 1, 1, 32'hCAFEF00D);
    chk("fl_cyc", wb.cyc, 1);
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    chk("fl_cyc_drop", wb.cyc, 0);
    chk("fl_no_hold", cpu_data, 0);
    drive(1, 0, 32'h480, 4'hF, 0, 0, 1, 0, 0);
    chk("fl_idle_stall", stallreq, 0);
    idle();
    chk("fl_idle_nocyc", wb.cyc, 0);

    // back-to-back: new request accepted in the IDLE cycle after ack
    drive(1, 0, 32'h500, 4'hF, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h500, 4'hF, 0, 0, 0, 1, 32'h11112222);
    chk("bb_data", cpu_data, 32'h11112222);
    drive(1, 1, 32'h504, 4'h3, 32'hAABBCCDD, 0, 0, 0, 0);
    chk("bb_req_stall", stallreq, 1);
    drive(1, 1, 32'h504, 4'h3, 32'hAABBCCDD, 0, 0, 1, 0);
    chk("bb_cyc", wb.cyc, 1);
    chk("bb_adr", wb.adr, 32'h504);
    idle();

`ifdef DBUS_TIMEOUT_EN
    drive(1, 0, 32'h600, 4'hF, 0, 0, 0, 0, 0);
    for (int i = 0; i < TO; i++) begin
      drive(1, 0, 32'h600, 4'hF, 0, 0, 0, 0, 0);
      chk("to_err", err, (i == TO - 1));
      chk("to_stall", stallreq, (i != TO - 1));
      chk("to_data", cpu_data, 0);
    end
    idle();
    chk("to_cyc_drop", wb.cyc, 0);
    chk("to_err_pulse", err, 0);
`endif

    // asynchronous reset in the middle of a store
    drive(1, 1, 32'h700, 4'hF, 32'hDEAD0000, 0, 0, 0, 0);
    drive(1, 1, 32'h700, 4'hF, 32'hDEAD0000, 0, 0, 0, 0);
    chk("ar_cyc_pre", wb.cyc, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("ar_cyc", wb.cyc, 0);
    chk("ar_stb", wb.stb, 0);
    chk("ar_we", wb.we, 0);
    @(posedge clk); #1;
    rst = 1'b1; ce = 1'b0;
    @(negedge clk);
    idle();
    chk("ar_idle_cyc", wb.cyc, 0);
    chk("ar_adr_clr", wb.adr, 0);
    idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
